significand_divider: RTL and testbench

Iterative restoring divider for the significands of two FP16-style operands. Produces a normalized, rounded BIT_WIDTH-bit mantissa plus the flags the exponent path needs. Forms the division half of the Softmax normalization datapath, next to the shift-add significand multiplier. It is a multi-cycle unit with a start/valid handshake, computing one quotient bit per cycle.

---
 rtl/sig_div_pkg.sv | 22 ++
 rtl/counter.sv | 36 +++
 rtl/dff.sv | 21 ++
 rtl/sig_div_rounder.sv | 43 ++++
 rtl/significand_divider.sv | 117 +++++++++++
 tb/tb_significand_divider.sv | 189 ++++++++++++++++++
 6 files changed

// File: rtl/sig_div_pkg.sv
// Shared state encoding and sizing helpers for the significand divider.
// No logic, so no latency and no flow control.
package sig_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DIVIDE = 2'b01,
        ST_VALID  = 2'b10
    } sig_div_state_e;

    localparam int SIG_DIV_BIT_WIDTH = 10;

    // One quotient bit per cycle: hidden bit, BIT_WIDTH fraction bits, then G/R/S.
    function automatic int iter_count(input int bit_width);
        return bit_width + 4;
    endfunction

    function automatic int cnt_width(input int bit_width);
        return $clog2(bit_width + 4);
    endfunction

endpackage

// File: rtl/counter.sv
// Up-counter with synchronous clear (priority over enable) and async reset.
// Latency 1 cycle; no flow control, holds its value while en_i is low.
module counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] ONE = 1;

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dff.sv
// Generic register with asynchronous active-low reset to RESET_VAL.
// Latency 1 cycle; no flow control, loads every cycle.
module dff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= RESET_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/sig_div_rounder.sv
// Normalizes the raw quotient and rounds to nearest-even when SIGNIFICAND_DIVIDER_ROUND_EN is defined, else truncates.
// Purely combinational (zero latency); no flow control.
module sig_div_rounder
    import sig_div_pkg::*;
#(
    parameter int  BIT_WIDTH = SIG_DIV_BIT_WIDTH,
    localparam int QW        = iter_count(BIT_WIDTH),
    localparam int RW        = BIT_WIDTH + 2
) (
    input  logic [QW-1:0]        q_i,
    input  logic [RW-1:0]        r_i,
    output logic [BIT_WIDTH-1:0] result_o,
    output logic                 significand_msb_o,
    output logic                 round_overflow_o
);

    localparam int MSB = QW - 1;

    logic [BIT_WIDTH-1:0] mant;

    assign significand_msb_o = q_i[MSB];
    // A quotient below 1 drops its leading zero and gains one more fraction bit.
    assign mant = q_i[MSB] ? q_i[MSB-1:3] : q_i[MSB-2:2];

`ifdef SIGNIFICAND_DIVIDER_ROUND_EN
    logic rem_nz, guard, round_bit, sticky, inc;

    assign rem_nz    = |r_i;
    assign guard     = q_i[MSB] ? q_i[2] : q_i[1];
    assign round_bit = q_i[MSB] ? q_i[1] : q_i[0];
    assign sticky    = q_i[MSB] ? (q_i[0] | rem_nz) : rem_nz;
    assign inc       = guard & (round_bit | sticky | mant[0]);

    assign {round_overflow_o, result_o} = {1'b0, mant} + {{BIT_WIDTH{1'b0}}, inc};
`else
    logic unused_grs;

    assign unused_grs       = ^{q_i[1:0], r_i};
    assign result_o         = mant;
    assign round_overflow_o = 1'b0;
`endif

endmodule

// File: rtl/significand_divider.sv
// Restoring significand divider, one quotient bit per cycle; rounding via SIGNIFICAND_DIVIDER_ROUND_EN.
// valid pulses BIT_WIDTH+5 cycles after start; start is ignored while busy (no queueing).
module significand_divider
    import sig_div_pkg::*;
#(
    parameter int BIT_WIDTH = SIG_DIV_BIT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] input_a,
    input  logic [BIT_WIDTH-1:0] input_b,
    input  logic                 hidden_bit_a,
    input  logic                 hidden_bit_b,
    output logic [BIT_WIDTH-1:0] result,
    output logic                 valid,
    output logic                 significand_msb,
    output logic                 round_overflow,
    output logic                 div_by_zero,
    output logic                 busy
);

    localparam int               ITER      = iter_count(BIT_WIDTH);
    localparam int               CNT_W     = cnt_width(BIT_WIDTH);
    localparam int               RW        = BIT_WIDTH + 2;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

    sig_div_state_e       state_d;
    logic [1:0]           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [RW-1:0]        rem_q, rem_d;
    logic [ITER-1:0]      quo_q, quo_d;
    logic [BIT_WIDTH:0]   div_q, div_d;
    logic                 dbz_q, dbz_d;
    logic                 load, step, rem_ge;
    logic [RW-2:0]        rem_diff;
    logic [BIT_WIDTH-1:0] rnd_result;
    logic                 rnd_msb, rnd_ovf;

    dff #(.WIDTH(2), .RESET_VAL(ST_IDLE)) u_state (
        .clk_i  (clk),
        .rst_ni (reset_b),
        .d_i    (state_d),
        .q_o    (state_q)
    );

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:   state_d = start ? ST_DIVIDE : ST_IDLE;
            ST_DIVIDE: state_d = (cnt_q == LAST_ITER) ? ST_VALID : ST_DIVIDE;
            ST_VALID:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign load  = (state_q == ST_IDLE) && start;
    assign step  = (state_q == ST_DIVIDE);
    assign valid = (state_q == ST_VALID);
    assign busy  = (state_q != ST_IDLE);

    counter #(.WIDTH(CNT_W)) u_iter (
        .clk_i  (clk),
        .rst_ni (reset_b),
        .clr_i  (load),
        .en_i   (step),
        .cnt_o  (cnt_q)
    );

    // Divisor is captured at launch so operand changes mid-division are harmless.
    assign rem_ge   = rem_q >= {1'b0, div_q};
    assign rem_diff = rem_q[RW-2:0] - div_q;

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        div_d = div_q;
        dbz_d = dbz_q;
        if (load) begin
            rem_d = {1'b0, hidden_bit_a, input_a};
            quo_d = '0;
            div_d = {hidden_bit_b, input_b};
            dbz_d = ({hidden_bit_b, input_b} == '0);
        end else if (step) begin
            rem_d = rem_ge ? {rem_diff, 1'b0} : {rem_q[RW-2:0], 1'b0};
            quo_d = {quo_q[ITER-2:0], rem_ge};
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            div_q <= div_d;
            dbz_q <= dbz_d;
        end
    end

    sig_div_rounder #(.BIT_WIDTH(BIT_WIDTH)) u_rounder (
        .q_i               (quo_q),
        .r_i               (rem_q),
        .result_o          (rnd_result),
        .significand_msb_o (rnd_msb),
        .round_overflow_o  (rnd_ovf)
    );

    assign result          = dbz_q ? '1 : rnd_result;
    assign significand_msb = dbz_q ? 1'b1 : rnd_msb;
    assign round_overflow  = dbz_q ? 1'b0 : rnd_ovf;
    assign div_by_zero     = dbz_q;

endmodule

// File: tb/tb_significand_divider.sv
// Directed bench for significand_divider: latency, normalization, rounding, divide-by-zero, busy and reset.
module tb_significand_divider;

    logic       clk = 1'b0;
    logic       reset_b;
    logic       start;
    logic [9:0] input_a, input_b;
    logic       hidden_bit_a, hidden_bit_b;
    logic [9:0] result;
    logic       valid, significand_msb, round_overflow, div_by_zero, busy;

    int n_vec = 0;
    int n_err = 0;

`ifdef SIGNIFICAND_DIVIDER_ROUND_EN
    localparam logic [9:0] EXP_125_OVER_15 = 10'h2AB;
    localparam logic [9:0] EXP_1_OVER_7FF  = 10'h001;
`else
    localparam logic [9:0] EXP_125_OVER_15 = 10'h2AA;
    localparam logic [9:0] EXP_1_OVER_7FF  = 10'h000;
`endif

    significand_divider dut (
        .clk             (clk),
        .reset_b         (reset_b),
        .start           (start),
        .input_a         (input_a),
        .input_b         (input_b),
        .hidden_bit_a    (hidden_bit_a),
        .hidden_bit_b    (hidden_bit_b),
        .result          (result),
        .valid           (valid),
        .significand_msb (significand_msb),
        .round_overflow  (round_overflow),
        .div_by_zero     (div_by_zero),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one division from IDLE and check latency, single pulse, outputs and hold.
    task automatic run_div(input string tag, input logic [10:0] a, input logic [10:0] b,
                           input logic [9:0] exp_res, input logic exp_msb, input logic exp_dbz);
        int         vcyc       = -1;
        int         npulse     = 0;
        logic       busy_first = 1'b0;
        logic       busy_after = 1'b1;
        logic [9:0] res_cap    = '0;
        logic       msb_cap    = 1'b0;
        logic       ovf_cap    = 1'b1;
        logic       dbz_cap    = 1'b0;
        @(negedge clk);
        {hidden_bit_a, input_a} = a;
        {hidden_bit_b, input_b} = b;
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start      = 1'b0;
                busy_first = busy;
            end
            if (k == 16) busy_after = busy;
            if (valid) begin
                npulse++;
                if (vcyc < 0) begin
                    vcyc    = k;
                    res_cap = result;
                    msb_cap = significand_msb;
                    ovf_cap = round_overflow;
                    dbz_cap = div_by_zero;
                end
            end
        end
        chk({tag, " latency"}, 32'(vcyc), 32'd15);
        chk({tag, " pulses"}, 32'(npulse), 32'd1);
        chk({tag, " busy_run"}, 32'(busy_first), 32'd1);
        chk({tag, " busy_after"}, 32'(busy_after), 32'd0);
        chk({tag, " result"}, 32'(res_cap), 32'(exp_res));
        chk({tag, " msb"}, 32'(msb_cap), 32'(exp_msb));
        chk({tag, " ovf"}, 32'(ovf_cap), 32'd0);
        chk({tag, " dbz"}, 32'(dbz_cap), 32'(exp_dbz));
        chk({tag, " hold"}, 32'(result), 32'(exp_res));
    endtask

    initial begin
        int         p1, p2, np, nv;
        logic [9:0] r1, r2;
        logic       m1, m2;

        reset_b      = 1'b0;
        start        = 1'b0;
        input_a      = '0;
        input_b      = '0;
        hidden_bit_a = 1'b0;
        hidden_bit_b = 1'b0;
        #2;
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst result", 32'(result), 32'd0);
        chk("rst msb", 32'(significand_msb), 32'd0);
        chk("rst ovf", 32'(round_overflow), 32'd0);
        chk("rst dbz", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        reset_b = 1'b1;

        run_div("1/1",       11'h400, 11'h400, 10'h000, 1'b1, 1'b0);
        run_div("1/1.5",     11'h400, 11'h600, 10'h155, 1'b0, 1'b0);
        run_div("1.5/1",     11'h600, 11'h400, 10'h200, 1'b1, 1'b0);
        run_div("1.25/1.5",  11'h500, 11'h600, EXP_125_OVER_15, 1'b0, 1'b0);
        run_div("1/1.25",    11'h400, 11'h500, 10'h266, 1'b0, 1'b0);
        run_div("1/1.999",   11'h400, 11'h7FF, EXP_1_OVER_7FF, 1'b0, 1'b0);
        run_div("div0",      11'h400, 11'h000, 10'h3FF, 1'b1, 1'b1);

        // start held high: back-to-back divisions, operands changed mid-DIVIDE.
        p1 = -1; p2 = -1; np = 0;
        r1 = '0; r2 = '0; m1 = 1'b0; m2 = 1'b1;
        @(negedge clk);
        {hidden_bit_a, input_a} = 11'h600;
        {hidden_bit_b, input_b} = 11'h400;
        start = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (k == 5) begin
                {hidden_bit_a, input_a} = 11'h400;
                {hidden_bit_b, input_b} = 11'h600;
            end
            if (k == 17) start = 1'b0;
            if (k == 20) begin
                {hidden_bit_a, input_a} = 11'h7FF;
                {hidden_bit_b, input_b} = 11'h400;
            end
            if (valid) begin
                np++;
                if (np == 1) begin
                    p1 = k; r1 = result; m1 = significand_msb;
                end else if (np == 2) begin
                    p2 = k; r2 = result; m2 = significand_msb;
                end
            end
        end
        chk("b2b first_lat", 32'(p1), 32'd15);
        chk("b2b period", 32'(p2 - p1), 32'd16);
        chk("b2b pulses", 32'(np), 32'd2);
        chk("b2b res1", 32'(r1), 32'h200);
        chk("b2b msb1", 32'(m1), 32'd1);
        chk("b2b res2", 32'(r2), 32'h155);
        chk("b2b msb2", 32'(m2), 32'd0);

        // Reset in the middle of a division.
        nv = 0;
        @(negedge clk);
        {hidden_bit_a, input_a} = 11'h400;
        {hidden_bit_b, input_b} = 11'h600;
        start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 6) chk("midrst busy_before", 32'(busy), 32'd1);
            if (k == 7) begin
                reset_b = 1'b0;
                #1;
                chk("midrst outputs",
                    32'({valid, busy, significand_msb, round_overflow, div_by_zero, result}), 32'd0);
            end
            if (k == 9) reset_b = 1'b1;
            if (k > 7 && valid) nv++;
        end
        chk("midrst no_valid", 32'(nv), 32'd0);
        run_div("post_rst", 11'h500, 11'h600, EXP_125_OVER_15, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
